// File: rtl/demux_route_pkg.sv
// Package for the registered 1-to-3 dispatch stage (demux_route_stage).
// Contents:
//   SEL_A/SEL_B/SEL_C/SEL_BAD : destination select codes
//   slot_state_t              : per-output slot state (EMPTY/FULL)
package demux_route_pkg;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One output slot of demux_route_stage: a single-entry holding register
// with valid, a delivered-word counter and its load/drain logic.
// Ports:
//   Clk, Rst     clock, asynchronous active-high reset
//   i_load       top has accepted a word aimed at this slot
//   i_data       word to load
//   o_can_load   slot can take a word this cycle (empty, or draining now)
//   o_valid      slot holds a word
//   i_ready      consumer takes the word
//   o_data       held word (stable while o_valid & !i_ready)
//   o_cnt        words delivered, wraps modulo 2^CNT_W
//
// state      | meaning
// SLOT_EMPTY | no word held, o_valid=0
// SLOT_FULL  | word held in r_data, o_valid=1
module demux_out_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_can_load,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);
  import demux_route_pkg::*;

  slot_state_t      r_state;
  slot_state_t      w_next;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign o_valid    = (r_state == SLOT_FULL);
  assign w_drain    = o_valid & i_ready;
  // A full slot that drains this cycle can take a new word with no bubble.
  assign o_can_load = ~o_valid | i_ready;
  assign o_data     = r_data;
  assign o_cnt      = r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_next = SLOT_FULL;
      SLOT_FULL:  if (i_ready && !i_load) w_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (i_load)  r_data <= i_data;
      if (w_drain) r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_route_stage.sv
// Registered 1-to-3 demultiplexer with valid/ready handshakes.
// sel: 0->A, 1->B, 2/3->C. Each output holds one word; a stalled consumer
// only blocks words aimed at it. Latency is one cycle.
// Optional build macro SEL_ERR_EN: sel==3 is accepted and dropped, and the
// sticky sel_err output sets; without it sel==3 routes to C and sel_err
// is absent.
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/in_data producer handshake and word
//   sel                       destination select, sampled with in_data
//   out_x_valid/ready/data    per-output handshake and word (x = a,b,c)
//   cnt_x                     per-output delivered-word counter
//   sel_err                   sticky illegal-select flag (SEL_ERR_EN)
module demux_route_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_c_valid,
  input  logic             out_c_ready,
  output logic [WIDTH-1:0] out_c_data,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
`ifdef SEL_ERR_EN
  ,
  output logic             sel_err
`endif
);
  import demux_route_pkg::*;

  logic [2:0] w_can;
  logic [2:0] w_load;
  logic       w_accept;

  // in_ready looks only at the selected slot, even when in_valid=0.
  always_comb begin
    in_ready = 1'b0;
    case (sel)
      SEL_A:   in_ready = w_can[0];
      SEL_B:   in_ready = w_can[1];
`ifdef SEL_ERR_EN
      SEL_BAD: in_ready = 1'b1;
`endif
      default: in_ready = w_can[2];
    endcase
  end

  assign w_accept  = in_valid & in_ready;
  assign w_load[0] = w_accept & (sel == SEL_A);
  assign w_load[1] = w_accept & (sel == SEL_B);
`ifdef SEL_ERR_EN
  assign w_load[2] = w_accept & (sel == SEL_C);

  logic r_sel_err;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                              r_sel_err <= 1'b0;
    else if (w_accept && sel == SEL_BAD)  r_sel_err <= 1'b1;
  end
  assign sel_err = r_sel_err;
`else
  // Both upper codes route to C.
  assign w_load[2] = w_accept & sel[1];
`endif

  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .Clk(Clk), .Rst(Rst), .i_load(w_load[0]), .i_data(in_data),
    .o_can_load(w_can[0]), .o_valid(out_a_valid), .i_ready(out_a_ready),
    .o_data(out_a_data), .o_cnt(cnt_a)
  );

  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .Clk(Clk), .Rst(Rst), .i_load(w_load[1]), .i_data(in_data),
    .o_can_load(w_can[1]), .o_valid(out_b_valid), .i_ready(out_b_ready),
    .o_data(out_b_data), .o_cnt(cnt_b)
  );

  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_c (
    .Clk(Clk), .Rst(Rst), .i_load(w_load[2]), .i_data(in_data),
    .o_can_load(w_can[2]), .o_valid(out_c_valid), .i_ready(out_c_ready),
    .o_data(out_c_data), .o_cnt(cnt_c)
  );

endmodule
